// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_responder_pkg
// Brief    : Shared types for the data-memory responder: request/response
//            buses, responder FSM states and the queued request entry.
// Revision : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

  // Core data-memory request bus
  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  // Core data-memory response bus
  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } responder_state_type;

  // One pending request held in the responder queue
  typedef struct packed {
    logic        fence;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } resp_entry_type;

  localparam int c_queue_depth = 2;
  // Wide enough for the longest wait: 15 latency cycles plus 3 stall cycles
  localparam int c_lat_w       = 5;

  // A read is anything that is neither a fence nor carries a write strobe
  function automatic logic entry_is_read(resp_entry_type e);
    return !e.fence && (e.wstrb == 4'h0);
  endfunction

  // Fences never touch RAM contents, whatever their strobes say
  function automatic logic [3:0] entry_byte_en(resp_entry_type e);
    return e.fence ? 4'h0 : e.wstrb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_responder_if
// Brief     : Request/response bundle between a data-memory initiator
//             (master) and the memory responder (slave).
// Revision  : 1.0 - initial release
// ============================================================================
interface mem_responder_if;
  import mem_responder_pkg::*;

  mem_in_type  mem_in;
  mem_out_type mem_out;

  modport master (output mem_in, input mem_out);
  modport slave  (input mem_in, output mem_out);

endinterface
`default_nettype wire

// File: rtl/responder_ram.sv
`default_nettype none
// ============================================================================
// Module   : responder_ram
// Brief    : Single-port 32-bit RAM, synchronous read, four byte enables.
//            A write leaves the read register untouched.
// Revision : 1.0 - initial release
// ============================================================================
module responder_ram #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write when any enable is set, otherwise a registered read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we != 4'h0) begin
        for (int b = 0; b < 4; b++) begin
          if (we[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Memory-side responder for the core data-memory bus. Serves
//            reads, byte-strobed writes and fences from internal RAM with a
//            programmable response latency and a 2-entry request queue.
// Macros   : MEM_RESPONDER_STALL_EN - adds 0..3 LFSR-driven wait cycles on
//            every service start to stress initiators.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_DEPTH   = 1024,
  parameter int MEM_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus,
  output logic           err
);

  localparam int c_addr_w = $clog2(RAM_DEPTH);

  responder_state_type  state, next_state;
  logic [c_lat_w-1:0]   cnt, cnt_next;
  logic [c_lat_w-1:0]   extra, start_len;
  resp_entry_type       slots [c_queue_depth];
  resp_entry_type       head, incoming;
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           count;
  logic                 push, pop;
  logic                 ready_q, read_q;
  logic                 ram_en;
  logic [3:0]           ram_we;
  logic [31:0]          ram_rdata;
  logic                 unused_bits;

  assign incoming = '{fence: bus.mem_in.mem_fence, addr: bus.mem_in.mem_addr,
                      wdata: bus.mem_in.mem_wdata, wstrb: bus.mem_in.mem_wstrb};
  assign head     = slots[rd_ptr];
  // A full queue still accepts a request when the head leaves in the same cycle
  assign push     = bus.mem_in.mem_valid && ((count != 2'd2) || pop);

`ifdef MEM_RESPONDER_STALL_EN
  logic [15:0] lfsr;

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign extra = {3'b000, lfsr[1:0]};
`else
  assign extra = '0;
`endif

  // A request already queued has had its acceptance cycle overlap the previous
  // response, so it needs one wait cycle fewer than a freshly arriving one;
  // with latency 1 this lets a response follow a response with no bubble.
  assign start_len = (count != 2'd0) ? (c_lat_w'(MEM_LATENCY - 1) + extra)
                                     : (c_lat_w'(MEM_LATENCY) + extra);

  // Next-state logic: start service, count down the latency, pop into RESP
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    case (state)
      IDLE, RESP: begin
        if ((count != 2'd0) || bus.mem_in.mem_valid) begin
          if (start_len == '0) begin
            next_state = RESP;
            pop        = 1'b1;
          end else begin
            next_state = WAIT;
            cnt_next   = start_len - c_lat_w'(1);
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          next_state = RESP;
          pop        = 1'b1;
        end else begin
          cnt_next = cnt - c_lat_w'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM state, latency counter and registered response flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_next;
      ready_q <= pop;
      read_q  <= pop && entry_is_read(head);
    end
  end

  // Queue pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      err    <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      if (bus.mem_in.mem_valid && !push) begin
        err <= 1'b1;
      end
    end
  end

  // Queue payload storage; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) begin
      slots[wr_ptr] <= incoming;
    end
  end

  // The head's RAM action is committed on the edge that enters RESP; reset
  // blocks it so an uncommitted write never lands.
  assign ram_en = pop && rst;
  assign ram_we = entry_byte_en(head);

  responder_ram #(
    .DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (head.addr[2 +: c_addr_w]),
    .wdata (head.wdata),
    .rdata (ram_rdata)
  );

  assign bus.mem_out = '{mem_ready: ready_q,
                         mem_rdata: (read_q ? ram_rdata : 32'h0)};

  assign unused_bits = ^{bus.mem_in.mem_instr, head.addr[31:2+c_addr_w], head.addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed self-checking bench for mem_responder. Three instances
//            with latencies 1, 3 and 4 share clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk;
  logic rst;
  logic err1, err3, err4;
  int   checks = 0;
  int   errors = 0;

  mem_responder_if bus1 ();
  mem_responder_if bus3 ();
  mem_responder_if bus4 ();

  mem_responder #(.RAM_DEPTH(1024), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .err(err1));
  mem_responder #(.RAM_DEPTH(1024), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .err(err3));
  mem_responder #(.RAM_DEPTH(1024), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .err(err4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; all driving and sampling happens 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic mem_in_type req(logic fence, logic [31:0] addr,
                                     logic [31:0] wdata, logic [3:0] wstrb);
    mem_in_type r;
    r           = '0;
    r.mem_valid = 1'b1;
    r.mem_fence = fence;
    r.mem_addr  = addr;
    r.mem_wdata = wdata;
    r.mem_wstrb = wstrb;
    return r;
  endfunction

  task automatic drive(int d, mem_in_type v);
    case (d)
      1:       bus1.mem_in = v;
      3:       bus3.mem_in = v;
      default: bus4.mem_in = v;
    endcase
  endtask

  function automatic logic get_ready(int d);
    case (d)
      1:       return bus1.mem_out.mem_ready;
      3:       return bus3.mem_out.mem_ready;
      default: return bus4.mem_out.mem_ready;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(int d);
    case (d)
      1:       return bus1.mem_out.mem_rdata;
      3:       return bus3.mem_out.mem_rdata;
      default: return bus4.mem_out.mem_rdata;
    endcase
  endfunction

  // Bounded wait for the next ready pulse, then check its data
  task automatic wait_resp(int d, string tag, logic [31:0] exp);
    int n = 0;
    while (get_ready(d) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 32'(get_ready(d)), 32'h1);
    chk({tag, "_rdata"}, get_rdata(d), exp);
    tick();
  endtask

  task automatic transact(int d, mem_in_type v, string tag, logic [31:0] exp);
    drive(d, v);
    tick();
    drive(d, '0);
    wait_resp(d, tag, exp);
  endtask

  initial begin
    rst = 1'b0;
    drive(1, '0);
    drive(3, '0);
    drive(4, '0);
    repeat (3) tick();
    chk("rst_ready", 32'(get_ready(1)), 32'h0);
    chk("rst_rdata", get_rdata(1), 32'h0);
    chk("rst_err1", 32'(err1), 32'h0);
    chk("rst_err4", 32'(err4), 32'h0);
    rst = 1'b1;
    tick();

    // Full-word write then read, exact latency-1 timing
    drive(1, req(1'b0, 32'h10, 32'hDEADBEEF, 4'hF));
    tick();
    chk("t1_wait", 32'(get_ready(1)), 32'h0);
    drive(1, req(1'b0, 32'h10, 32'h0, 4'h0));
    tick();
    chk("t1_wr_ready", 32'(get_ready(1)), 32'h1);
    chk("t1_wr_rdata", get_rdata(1), 32'h0);
    drive(1, '0);
    tick();
    chk("t1_rd_ready", 32'(get_ready(1)), 32'h1);
    chk("t1_rd_rdata", get_rdata(1), 32'hDEADBEEF);
    tick();
    chk("t1_idle", 32'(get_ready(1)), 32'h0);

    // Single-byte merge into the existing word
    transact(1, req(1'b0, 32'h10, 32'h000000AA, 4'h1), "t2_wr", 32'h0);
    transact(1, req(1'b0, 32'h10, 32'h0, 4'h0), "t2_rd", 32'hDEADBEAA);

    // Back-to-back writes then back-to-back reads at latency 1
    for (int i = 0; i < 8; i++) begin
      drive(1, req(1'b0, 32'(4 * i), 32'hA5000000 + 32'(i), 4'hF));
      tick();
    end
    drive(1, '0);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, (i < 8) ? req(1'b0, 32'(4 * i), 32'h0, 4'h0) : '0);
      tick();
      if (i == 0 || i == 9) begin
        chk("t4_edge_ready", 32'(get_ready(1)), 32'h0);
      end else begin
        chk("t4_ready", 32'(get_ready(1)), 32'h1);
        chk("t4_rdata", get_rdata(1), 32'hA5000000 + 32'(i - 1));
      end
    end

    // Latency 3: ready exactly three cycles after acceptance
    transact(3, req(1'b0, 32'h40, 32'h12345678, 4'hF), "t3_wr", 32'h0);
    drive(3, req(1'b0, 32'h40, 32'h0, 4'h0));
    tick();
    drive(3, '0);
    for (int k = 0; k < 5; k++) begin
      chk("t3_lat_ready", 32'(get_ready(3)), (k == 3) ? 32'h1 : 32'h0);
      if (k == 3) begin
        chk("t3_lat_rdata", get_rdata(3), 32'h12345678);
      end
      tick();
    end

    // Fence: zero data, RAM word left intact
    transact(3, req(1'b0, 32'h20, 32'hCAFEF00D, 4'hF), "t6_wr", 32'h0);
    transact(3, req(1'b0, 32'h20, 32'h0, 4'h0), "t6_rd", 32'hCAFEF00D);
    drive(3, req(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF));
    tick();
    drive(3, '0);
    for (int k = 0; k < 4; k++) begin
      chk("t6_fence_ready", 32'(get_ready(3)), (k == 3) ? 32'h1 : 32'h0);
      if (k == 3) begin
        chk("t6_fence_rdata", get_rdata(3), 32'h0);
      end
      tick();
    end
    transact(3, req(1'b0, 32'h20, 32'h0, 4'h0), "t6_rd_after", 32'hCAFEF00D);

    // Latency 4: three requests back to back, third one overflows
    drive(4, req(1'b0, 32'h8, 32'h11111111, 4'hF));
    tick();
    chk("t5_err_clear", 32'(err4), 32'h0);
    drive(4, req(1'b0, 32'h8, 32'h0, 4'h0));
    tick();
    drive(4, req(1'b0, 32'h8, 32'h22222222, 4'hF));
    tick();
    drive(4, '0);
    chk("t5_err_set", 32'(err4), 32'h1);
    wait_resp(4, "t5_first", 32'h0);
    wait_resp(4, "t5_second", 32'h11111111);
    transact(4, req(1'b0, 32'h8, 32'h0, 4'h0), "t5_dropped", 32'h11111111);
    chk("t5_err_sticky", 32'(err4), 32'h1);

    // Reset while a write is still waiting on dut3
    drive(3, req(1'b0, 32'h20, 32'h0BADBEEF, 4'hF));
    tick();
    drive(3, '0);
    rst = 1'b0;
    tick();
    chk("rst2_err4", 32'(err4), 32'h0);
    chk("rst2_ready3", 32'(get_ready(3)), 32'h0);
    rst = 1'b1;
    repeat (6) tick();
    chk("rst2_no_resp", 32'(get_ready(3)), 32'h0);
    transact(3, req(1'b0, 32'h20, 32'h0, 4'h0), "rst2_rd", 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core data-memory interface; terminates the request stream a write buffer or cache issues on mem_in_type.
- Serves word reads, byte-strobed writes and fences from an internal byte-enabled SRAM.
- Programmable response latency and a 2-entry request queue absorb requests that arrive while a response is pending.
- Used as the dmem model in simulation and as the tightly-coupled data RAM in small FPGA builds.

Parameters:
- ram_depth, 1024: RAM size in 32-bit words; power of two.
- mem_latency, 1: cycles from request acceptance to mem_ready; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low; clock clk.
- mem_in  in  mem_in_type  request: mem_valid, mem_fence, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]
- mem_out  out  mem_out_type  response: mem_ready (1), mem_rdata[31:0]
- err  out  1  sticky protocol error: a request was dropped on queue overflow

Behaviour:
- Reset (rst=0 at posedge): mem_ready=0, mem_rdata=0, err=0, queue empty, FSM=IDLE, latency counter=0. RAM contents are not cleared.
- A request is sampled in any cycle with mem_valid=1. There is no backpressure. mem_instr is ignored.
- Request kind:
  - fence: mem_fence=1 (takes priority over wstrb).
  - write: wstrb!=0.
  - read: wstrb=0.
- RAM word index = mem_addr[2 +: log2(ram_depth)]. Upper address bits are ignored, so addresses alias. mem_addr[1:0] is ignored.
- Queue: 2 entries of {fence, addr, wdata, wstrb}, strict FIFO.
  - A push with the queue full drops the request and sets err=1 until reset.
  - A push and a pop in the same cycle are both performed.
- FSM:
  - IDLE -> WAIT when the queue is non-empty, or a request arrives (bypass into the head slot). Load counter=mem_latency-1.
  - WAIT: decrement the counter each cycle. At 0, go to RESP.
  - RESP: assert mem_ready=1 for exactly one cycle, pop the head and perform its action.
    - Write: update only the bytes whose wstrb bit is set; mem_rdata=0.
    - Read: mem_rdata = RAM word after any earlier queued write.
    - Fence: mem_rdata=0.
    - Next state: WAIT if more work exists (including a request arriving in this same cycle), else IDLE.
- Timing: a request sampled at edge t gives mem_ready high in cycle t+mem_latency.
  - With mem_latency=1 and a new valid in every ready cycle, throughput is one response per cycle with no bubble.
- mem_ready and mem_rdata are registered; there are no combinational paths from mem_in to mem_out.
- Ordering: responses are returned strictly in request order. A read following a write to the same word returns the new data.
- Reset mid-operation: pending queue entries and any in-flight response are discarded; uncommitted writes do not reach the RAM.

Optional Feature:
- Macro MEM_RESPONDER_STALL_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) steps every cycle.
  - On entry to WAIT, lfsr[1:0] extra wait cycles (0..3) are added.
  - Data and ordering are unchanged. Used to stress initiators.
- Undefined: latency is exactly mem_latency and no LFSR logic is present.

Decomposition:
- Shared package wires: add responder_state_type enum {IDLE, WAIT, RESP} and resp_entry_type (fence 1, addr 32, wdata 32, wstrb 4).
- mem_in_type and mem_out_type are reused unchanged.
- One sub-module, responder_ram: single-port synchronous-read RAM with 4 byte enables, parameterised by depth.

Test Plan:
- After reset, write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; then read 0x10. Required: two ready pulses; read rdata=0xDEADBEEF.
- Write 0x10, wdata 0x000000AA, wstrb 0x1 over the previous word; read 0x10. Required: rdata=0xDEADBEAA.
- mem_latency=3: read issued at cycle 5. Required: mem_ready only in cycle 8; mem_ready=0 in cycles 6-7.
- mem_latency=1: back-to-back valid in every ready cycle, 8 reads of 0x0..0x1C. Required: 8 consecutive ready cycles, data in order.
- Three valids in consecutive cycles with mem_latency=4. Required:
  - The first two responses are returned in order.
  - The third request is dropped and err=1.
  - Reset clears err to 0.
- Fence (mem_fence=1, wstrb=0xF) at addr 0x20. Required: ready after mem_latency with rdata=0; the RAM word at 0x20 is unchanged.
